// File: rtl/booth_pkg.sv
// Shared Booth radix-4 digit decode types and helpers for the approximate multiplier family.
package booth_pkg;

  typedef struct packed {
    logic neg;
    logic two;
    logic zero;
  } booth_dig_t;

  function automatic int unsigned BOOTH_K(int unsigned n);
    return n / 2;
  endfunction

  function automatic booth_dig_t booth_decode(logic [2:0] g);
    booth_dig_t d;
    case (g)
      3'b001, 3'b010: d = '{neg: 1'b0, two: 1'b0, zero: 1'b0};
      3'b011:         d = '{neg: 1'b0, two: 1'b1, zero: 1'b0};
      3'b100:         d = '{neg: 1'b1, two: 1'b1, zero: 1'b0};
      3'b101, 3'b110: d = '{neg: 1'b1, two: 1'b0, zero: 1'b0};
      default:        d = '{neg: 1'b0, two: 1'b0, zero: 1'b1};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_pprow.sv
// One radix-4 Booth partial-product row with the approximate 2A path on the low m columns.
module booth_r4_pprow
  import booth_pkg::*;
#(
  parameter int N  = 10,
  parameter int MW = $clog2(N + 2)
) (
  input  logic [N:0]    xe,
  input  logic [2:0]    grp,
  input  logic [MW-1:0] m,
  input  logic          exact_neg,
  output logic [N+1:0]  row,
  output logic          corr
);

  booth_dig_t dig;
  logic [N:0] xs;
  logic       sel;

  assign dig = booth_decode(grp);
  assign xs  = {xe[N-1:0], 1'b0};

  // Columns below m keep the unshifted operand bit even when the digit asks for 2A.
  always_comb begin
    row = '0;
    sel = 1'b0;
    for (int unsigned t = 0; t <= N; t++) begin
      sel    = (dig.two && t >= 32'(m)) ? xs[t] : xe[t];
      row[t] = ~dig.zero & (dig.neg ^ sel);
    end
    row[N+1] = dig.neg;
    if (!exact_neg) row[0] = row[0] | dig.neg;
  end

  assign corr = exact_neg & dig.neg;

endmodule

// File: rtl/booth_r4_approx_pipe.sv
// Three-stage radix-4 Booth multiplier with per-beat approximation depth and valid/ready flow control.
module booth_r4_approx_pipe
  import booth_pkg::*;
#(
  parameter int N   = 10,
  parameter int MW  = $clog2(N + 2),
  parameter int IDW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_x,
  input  logic [N-1:0]     in_y,
  input  logic [MW-1:0]    in_m,
  input  logic             in_exact_neg,
  input  logic [IDW-1:0]   in_id,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_p,
  output logic [IDW-1:0]   out_id
);

  localparam int unsigned   K     = BOOTH_K(N);
  localparam int            PW    = 2 * N;
  localparam logic [MW-1:0] M_MAX = MW'(N + 1);

  logic adv;

  logic           s1_v_q, s1_v_d;
  logic [N-1:0]   x_q, x_d, y_q, y_d;
  logic [MW-1:0]  m_q, m_d;
  logic           exn_q, exn_d;
  logic [IDW-1:0] s1_id_q, s1_id_d;

  logic           s2_v_q, s2_v_d;
  logic [PW-1:0]  rows_q [K+1];
  logic [PW-1:0]  rows_d [K+1];
  logic [PW-1:0]  corr_q, corr_d;
  logic [IDW-1:0] s2_id_q, s2_id_d;

  logic           out_v_q, out_v_d;
  logic [PW-1:0]  p_q, p_d;
  logic [IDW-1:0] oid_q, oid_d;

  logic [N:0]     xe;
  logic [N+2:0]   ye;
  logic [N+1:0]   row_w [K+1];
  logic [K:0]     corr_w;

  assign adv       = ~out_v_q | out_ready;
  assign in_ready  = adv;
  assign out_valid = out_v_q;
  assign out_p     = p_q;
  assign out_id    = oid_q;

  assign xe = {1'b0, x_q};
  assign ye = {2'b00, y_q, 1'b0};

  for (genvar gi = 0; gi <= K; gi++) begin : g_row
    booth_r4_pprow #(.N(N), .MW(MW)) u_row (
      .xe        (xe),
      .grp       (ye[2*gi+2 -: 3]),
      .m         (m_q),
      .exact_neg (exn_q),
      .row       (row_w[gi]),
      .corr      (corr_w[gi])
    );
  end

  always_comb begin
    s1_v_d  = s1_v_q;
    x_d     = x_q;
    y_d     = y_q;
    m_d     = m_q;
    exn_d   = exn_q;
    s1_id_d = s1_id_q;
    if (adv) begin
      s1_v_d  = in_valid;
      x_d     = in_x;
      y_d     = in_y;
      m_d     = (in_m > M_MAX) ? M_MAX : in_m;
      exn_d   = in_exact_neg;
      s1_id_d = in_id;
    end
  end

  always_comb begin
    s2_v_d  = s2_v_q;
    rows_d  = rows_q;
    corr_d  = corr_q;
    s2_id_d = s2_id_q;
    if (adv) begin
      s2_v_d  = s1_v_q;
      s2_id_d = s1_id_q;
      corr_d  = '0;
      for (int unsigned i = 0; i <= K; i++) begin
        rows_d[i] = {{(PW-N-2){row_w[i][N+1]}}, row_w[i]} << (2 * i);
        corr_d    = corr_d | (PW'(corr_w[i]) << (2 * i));
      end
    end
  end

  always_comb begin
    out_v_d = out_v_q;
    p_d     = p_q;
    oid_d   = oid_q;
    if (adv) begin
      out_v_d = s2_v_q;
      oid_d   = s2_id_q;
      p_d     = corr_q;
      for (int unsigned i = 0; i <= K; i++) p_d = p_d + rows_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      m_q     <= '0;
      exn_q   <= 1'b0;
      s1_id_q <= '0;
      s2_v_q  <= 1'b0;
      for (int unsigned i = 0; i <= K; i++) rows_q[i] <= '0;
      corr_q  <= '0;
      s2_id_q <= '0;
      out_v_q <= 1'b0;
      p_q     <= '0;
      oid_q   <= '0;
    end else begin
      s1_v_q  <= s1_v_d;
      x_q     <= x_d;
      y_q     <= y_d;
      m_q     <= m_d;
      exn_q   <= exn_d;
      s1_id_q <= s1_id_d;
      s2_v_q  <= s2_v_d;
      rows_q  <= rows_d;
      corr_q  <= corr_d;
      s2_id_q <= s2_id_d;
      out_v_q <= out_v_d;
      p_q     <= p_d;
      oid_q   <= oid_d;
    end
  end

endmodule

// File: tb/tb_booth_r4_approx_pipe.sv
// Self-checking bench: directed vector table, random stream against an arithmetic Booth model, stall and reset sequences.
module tb_booth_r4_approx_pipe;

  localparam int N   = 10;
  localparam int MW  = $clog2(N + 2);
  localparam int IDW = 4;
  localparam int PW  = 2 * N;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_x;
  logic [N-1:0]     in_y;
  logic [MW-1:0]    in_m;
  logic             in_exact_neg;
  logic [IDW-1:0]   in_id;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    out_p;
  logic [IDW-1:0]   out_id;

  booth_r4_approx_pipe #(.N(N), .MW(MW), .IDW(IDW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_m         (in_m),
    .in_exact_neg (in_exact_neg),
    .in_id        (in_id),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_p        (out_p),
    .out_id       (out_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int m;
    bit en;
    int id;
    int p;
  } vec_t;

  typedef struct {
    logic [PW-1:0]  p;
    logic [IDW-1:0] id;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   fire_in, fire_out;

  // Digit value per group times an approximated |A|, summed with plain integer weights.
  function automatic logic [PW-1:0] model(int x, int y, int m, bit en);
    longint      acc = 0;
    logic [63:0] r;
    int          mc = (m > N + 1) ? N + 1 : m;
    longint      mask = (longint'(1) << mc) - 1;
    for (int i = 0; i <= N / 2; i++) begin
      int     hi = (2 * i + 1 < N) ? (y >> (2 * i + 1)) & 1 : 0;
      int     lo = (2 * i < N) ? (y >> (2 * i)) & 1 : 0;
      int     lm = (i > 0) ? (y >> (2 * i - 1)) & 1 : 0;
      int     d  = -2 * hi + lo + lm;
      longint a;
      longint row;
      if (d == 0) continue;
      if (d == 2 || d == -2) a = (longint'(x) & mask) | ((2 * longint'(x)) & ~mask);
      else a = x;
      if (d > 0) row = a;
      else if (en) row = -a;
      else row = -a - 1 + (a & 1);
      acc += row * (longint'(1) << (2 * i));
    end
    r = acc;
    return r[PW-1:0];
  endfunction

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive_beat(logic [N-1:0] x, logic [N-1:0] y, logic [MW-1:0] m, logic en, logic [IDW-1:0] id);
    in_valid     = 1'b1;
    in_x         = x;
    in_y         = y;
    in_m         = m;
    in_exact_neg = en;
    in_id        = id;
  endtask

  // Entered and left at posedge+1; checks the head of the scoreboard whenever a result is shown.
  task automatic cycle(string tag);
    #1;
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s_spurious: out_valid=1 with p=%0d id=%0d, expected no result", tag, out_p, out_id);
      end else begin
        check({tag, "_p"}, 64'(out_p), 64'(sb[0].p));
        check({tag, "_id"}, 64'(out_id), 64'(sb[0].id));
      end
    end
    fire_out = out_valid && out_ready && (sb.size() > 0);
    fire_in  = in_valid && in_ready;
    if (fire_out) void'(sb.pop_front());
    if (fire_in) sb.push_back('{p: model(int'(in_x), int'(in_y), int'(in_m), in_exact_neg), id: in_id});
    @(posedge clk);
    #1;
  endtask

  task automatic single(vec_t v, string nm);
    drive_beat(N'(v.x), N'(v.y), MW'(v.m), v.en, IDW'(v.id));
    out_ready = 1'b1;
    #1;
    check({nm, "_in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({nm, "_lat1_valid"}, 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check({nm, "_lat2_valid"}, 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check({nm, "_lat3_valid"}, 64'(out_valid), 64'(1));
    check({nm, "_p"}, 64'(out_p), 64'(v.p));
    check({nm, "_id"}, 64'(out_id), 64'(v.id));
    @(posedge clk); #1;
    check({nm, "_once"}, 64'(out_valid), 64'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[9];
    vt[0] = '{x: 700,  y: 1,    m: 6,  en: 1'b0, id: 5,  p: 700};
    vt[1] = '{x: 4,    y: 3,    m: 6,  en: 1'b0, id: 1,  p: 11};
    vt[2] = '{x: 4,    y: 3,    m: 6,  en: 1'b1, id: 2,  p: 12};
    vt[3] = '{x: 3,    y: 2,    m: 0,  en: 1'b1, id: 3,  p: 6};
    vt[4] = '{x: 3,    y: 2,    m: 0,  en: 1'b0, id: 4,  p: 5};
    vt[5] = '{x: 3,    y: 2,    m: 6,  en: 1'b0, id: 6,  p: 9};
    vt[6] = '{x: 1023, y: 1023, m: 0,  en: 1'b1, id: 7,  p: 1046529};
    vt[7] = '{x: 0,    y: 513,  m: 0,  en: 1'b1, id: 8,  p: 0};
    vt[8] = '{x: 1023, y: 2,    m: 15, en: 1'b1, id: 9,  p: 3069};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_x = '0; in_y = '0; in_m = '0; in_exact_neg = 1'b0; in_id = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_p", 64'(out_p), 64'(0));
    check("rst_out_id", 64'(out_id), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) single(vt[i], $sformatf("vec%0d", i));

    begin : rnd
      int sent = 0;
      int budget = 0;
      while ((sent < 3000 || sb.size() > 0) && budget < 30000) begin
        if (sent < 3000 && $urandom_range(0, 9) < 8) begin
          if ($urandom_range(0, 1) == 1)
            drive_beat(N'($urandom), N'($urandom), '0, 1'b1, IDW'($urandom));
          else
            drive_beat(N'($urandom), N'($urandom), MW'($urandom_range(0, 15)), 1'($urandom), IDW'($urandom));
        end else begin
          in_valid = 1'b0;
        end
        out_ready = ($urandom_range(0, 9) < 7);
        cycle("rnd");
        sent += int'(fire_in);
        budget++;
      end
      in_valid = 1'b0;
      if (budget >= 30000) begin
        n_checks++;
        n_fail++;
        $display("FAIL rnd_timeout: %0d beats sent, %0d pending, expected full drain", sent, sb.size());
      end
      check("rnd_drained", 64'(sb.size()), 64'(0));
    end

    begin : bp
      int k = 0;
      int dlv = 0;
      int stall = 0;
      out_ready = 1'b1;
      for (int c = 0; c < 60 && (k < 5 || sb.size() > 0); c++) begin
        if (k < 5) drive_beat(N'(37 * k + 11), N'(3 * k + 500), '0, 1'b1, IDW'(k + 8));
        else in_valid = 1'b0;
        out_ready = (dlv == 0) || (stall >= 4);
        #1;
        if (!out_ready && out_valid) begin
          stall++;
          check("bp_in_ready", 64'(in_ready), 64'(0));
          check("bp_held", 64'(sb.size()), 64'(3));
        end
        cycle("bp");
        k   += int'(fire_in);
        dlv += int'(fire_out);
      end
      in_valid = 1'b0;
      check("bp_all_in", 64'(k), 64'(5));
      check("bp_all_out", 64'(dlv), 64'(5));
      check("bp_stall_cycles", 64'(stall), 64'(4));
      check("bp_drained", 64'(sb.size()), 64'(0));
    end

    begin : rst_mid
      vec_t v;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
        drive_beat(N'(100 + k), N'(200 + k), '0, 1'b1, IDW'(k + 1));
        cycle("rstpre");
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rstmid_out_valid", 64'(out_valid), 64'(0));
      check("rstmid_out_p", 64'(out_p), 64'(0));
      check("rstmid_out_id", 64'(out_id), 64'(0));
      check("rstmid_in_ready", 64'(in_ready), 64'(1));
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rstmid_after_valid", 64'(out_valid), 64'(0));
      v = '{x: 15, y: 15, m: 0, en: 1'b1, id: 12, p: 225};
      single(v, "rstmid_15x15");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
